cdb_buffered: RTL and testbench

- Parametrised successor to the single-stage CDB arbiter.
- Adds a small per-source holding FIFO, so a functional unit that loses arbitration does not lose its result.
- Adds ready/valid backpressure to the FUs, a selectable fixed or round-robin arbitration policy, and a synchronous squash input.
- Sits between the EX-stage FU outputs and the PRF, RS wakeup and EX forwarding consumers of the registered CDB lanes.

---
 rtl/cdb_buffered_pkg.sv | 31 +++
 rtl/cdb_buffered_src_fifo.sv | 70 +++++++
 rtl/cdb_buffered.sv | 151 +++++++++++++++
 tb/tb_cdb_buffered.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_buffered_pkg.sv
// Shared types and defaults for the buffered common data bus.
package cdb_buffered_pkg;

  localparam int CDB_TAG_W     = 6;
  localparam int CDB_DATA_W    = 32;
  localparam int NUM_FU_TOTAL  = 4;
  localparam int CDB_N         = 2;
  localparam int CDB_SRC_DEPTH = 2;

  // One broadcast slot: the valid field is owned by the bus, not the producer
  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } CDB_ENTRY;

  // Mirrors the RR_MODE parameter: 0 = fixed priority, 1 = round-robin
  typedef enum logic {
    CDB_ARB_FIXED = 1'b0,
    CDB_ARB_RR    = 1'b1
  } cdb_arb_mode_e;

  // A granted result always goes out with valid set, whatever the FU put there
  function automatic CDB_ENTRY cdb_broadcast(input CDB_ENTRY e);
    CDB_ENTRY r;
    r       = e;
    r.valid = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/cdb_buffered_src_fifo.sv
// Small per-source holding FIFO; keeps results that lost arbitration in order.
module cdb_src_fifo
  import cdb_buffered_pkg::*;
#(
  parameter  int DEPTH = CDB_SRC_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  CDB_ENTRY      din,
  output CDB_ENTRY      head,
  output logic          empty,
  output logic [CW-1:0] count
);

  CDB_ENTRY        mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

  // Storage array needs no reset; count and pointers decide what is live
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; a flush empties the FIFO outright
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  a_count_bound : assert property (@(posedge clock) disable iff (!reset)
    count <= CW'(DEPTH));
  a_no_overflow : assert property (@(posedge clock) disable iff (!reset)
    !(push && !pop && count == CW'(DEPTH)));
  a_no_underflow : assert property (@(posedge clock) disable iff (!reset)
    !(pop && empty));

endmodule

// File: rtl/cdb_buffered.sv
// Buffered CDB arbiter: per-source FIFOs, ready/valid to the FUs,
// fixed or round-robin lane allocation and registered broadcast lanes.
module cdb_buffered
  import cdb_buffered_pkg::*;
#(
  parameter  int NUM_SRC = NUM_FU_TOTAL,
  parameter  int NUM_CDB = CDB_N,
  parameter  int DEPTH   = CDB_SRC_DEPTH,
  parameter  int RR_MODE = 0,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_SRC-1:0]           fu_valid,
  input  CDB_ENTRY [NUM_SRC-1:0]       fu_entry,
  output logic [NUM_SRC-1:0]           fu_ready,
  output CDB_ENTRY [NUM_CDB-1:0]       cdb_output,
  output logic [NUM_SRC-1:0][CW-1:0]   occupancy
);

  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int GW = $clog2(NUM_CDB + 1);
  localparam int LW = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;
  localparam cdb_arb_mode_e ARB_MODE = (RR_MODE != 0) ? CDB_ARB_RR : CDB_ARB_FIXED;

  logic [NUM_SRC-1:0]          empty;
  CDB_ENTRY [NUM_SRC-1:0]      head;
  logic [NUM_SRC-1:0]          accept;
  logic [NUM_SRC-1:0]          req;
  CDB_ENTRY [NUM_SRC-1:0]      req_entry;
  logic [NUM_SRC-1:0]          grant;
  logic [NUM_SRC-1:0]          push;
  logic [NUM_SRC-1:0]          pop;

  logic [NUM_CDB-1:0]          lane_vld;
  logic [NUM_CDB-1:0][SW-1:0]  lane_src;
  CDB_ENTRY [NUM_CDB-1:0]      lane_entry;

  logic [SW-1:0]               rr_ptr;
  logic [SW-1:0]               rr_next;
  logic [SW-1:0]               scan_base;
  logic [SW-1:0]               idx;
  logic [SW-1:0]               last;
  logic [GW-1:0]               ng;

  // Source index base+off wrapped modulo NUM_SRC (both operands below NUM_SRC)
  function automatic logic [SW-1:0] rot_idx(input logic [SW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= 32'(NUM_SRC)) begin
      sum = sum - 32'(NUM_SRC);
    end
    return SW'(sum);
  endfunction

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    cdb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .push  (push[s]),
      .pop   (pop[s]),
      .din   (fu_entry[s]),
      .head  (head[s]),
      .empty (empty[s]),
      .count (occupancy[s])
    );
    // Ready comes only from registered occupancy, so no path from grants or valid
    assign fu_ready[s] = (occupancy[s] < CW'(DEPTH));
  end

  // Each source requests with its oldest result: the FIFO head, else a bypassing new entry
  always_comb begin
    accept    = '0;
    req       = '0;
    req_entry = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      accept[s]    = fu_valid[s] & fu_ready[s];
      req[s]       = ~empty[s] | accept[s];
      req_entry[s] = empty[s] ? fu_entry[s] : head[s];
    end
  end

  // Priority scan from index 0 (fixed) or from rr_ptr (round-robin); k-th hit takes lane k
  always_comb begin
    grant      = '0;
    lane_vld   = '0;
    lane_src   = '0;
    lane_entry = '0;
    ng         = '0;
    idx        = '0;
    last       = rr_ptr;
    scan_base  = (ARB_MODE == CDB_ARB_RR) ? rr_ptr : '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      idx = rot_idx(scan_base, j);
      if (req[idx] && (ng < GW'(NUM_CDB))) begin
        grant[idx]             = 1'b1;
        lane_vld[ng[LW-1:0]]   = 1'b1;
        lane_src[ng[LW-1:0]]   = idx;
        lane_entry[ng[LW-1:0]] = cdb_broadcast(req_entry[idx]);
        ng                     = ng + 1'b1;
        last                   = idx;
      end
    end
    rr_next = (|grant) ? rot_idx(last, 1) : rr_ptr;
  end

  // A granted head leaves its FIFO; an accepted entry is stored unless it bypassed straight out
  always_comb begin
    push = '0;
    pop  = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      pop[s]  = grant[s] & ~empty[s];
      push[s] = accept[s] & ~(grant[s] & empty[s]);
    end
  end

  // Round-robin pointer survives a flush so fairness carries across squashes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (!flush) begin
      rr_ptr <= rr_next;
    end
  end

  // Registered broadcast lanes; ungranted lanes and squashed cycles go out as all-zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb_output <= '0;
    end else if (flush) begin
      cdb_output <= '0;
    end else begin
      for (int k = 0; k < NUM_CDB; k++) begin
        cdb_output[k] <= lane_vld[k] ? lane_entry[k] : '0;
      end
    end
  end

  a_lanes_le_reqs : assert property (@(posedge clock) disable iff (!reset)
    $countones(lane_vld) <= $countones(req));

  for (genvar k1 = 0; k1 < NUM_CDB; k1++) begin : g_uniq_a
    for (genvar k2 = k1 + 1; k2 < NUM_CDB; k2++) begin : g_uniq_b
      a_unique_src : assert property (@(posedge clock) disable iff (!reset)
        !(lane_vld[k1] && lane_vld[k2] && (lane_src[k1] == lane_src[k2])));
    end
  end

endmodule

// File: tb/tb_cdb_buffered.sv
// Scoreboard bench: a fixed-priority and a round-robin instance are each driven by
// FU-like producers and checked against a queue-based model of the bus.
module tb_cdb_buffered;
  import cdb_buffered_pkg::*;

  localparam int NSRC = 4;
  localparam int NCDB = 2;
  localparam int DEP  = 2;
  localparam int CW   = $clog2(DEP + 1);

  typedef CDB_ENTRY [NCDB-1:0] lanes_t;

  logic clock;
  logic reset;
  logic [NSRC-1:0]         fv0, fv1;
  CDB_ENTRY [NSRC-1:0]     fe0, fe1;
  logic                    fl0, fl1;
  logic [NSRC-1:0]         rdy0, rdy1;
  CDB_ENTRY [NCDB-1:0]     out0, out1;
  logic [NSRC-1:0][CW-1:0] occ0, occ1;

  CDB_ENTRY mq [2][NSRC][$];
  int       mrr [2];
  lanes_t   exp_q [2][$];
  bit       pend_v [2][NSRC];
  CDB_ENTRY pend_e [2][NSRC];
  int       next_tag [2];
  int       compared = 0;
  int       mismatched = 0;

  cdb_buffered #(.NUM_SRC(NSRC), .NUM_CDB(NCDB), .DEPTH(DEP), .RR_MODE(0)) dut_fixed (
    .clock(clock), .reset(reset), .flush(fl0), .fu_valid(fv0), .fu_entry(fe0),
    .fu_ready(rdy0), .cdb_output(out0), .occupancy(occ0)
  );

  cdb_buffered #(.NUM_SRC(NSRC), .NUM_CDB(NCDB), .DEPTH(DEP), .RR_MODE(1)) dut_rr (
    .clock(clock), .reset(reset), .flush(fl1), .fu_valid(fv1), .fu_entry(fe1),
    .fu_ready(rdy1), .cdb_output(out1), .occupancy(occ1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_value(input string name, input int inst, input logic [63:0] act,
                             input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s inst%0d t=%0t: got %h expected %h", name, inst, $time, act, req);
    end
  endtask

  task automatic check_output(input int i, input lanes_t expl);
    for (int k = 0; k < NCDB; k++) begin
      check_value("lane", i, 64'((i == 0) ? out0[k] : out1[k]), 64'(expl[k]));
    end
  endtask

  // Monitor: one expected lane set per clock edge, popped just after the edge
  always @(posedge clock) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (exp_q[i].size() > 0) begin
        check_output(i, exp_q[i].pop_front());
      end
    end
  end

  task automatic check_reset_state();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < NCDB; k++) begin
        check_value("reset_lane", i, 64'((i == 0) ? out0[k] : out1[k]), 64'(0));
      end
      for (int s = 0; s < NSRC; s++) begin
        check_value("reset_ready", i, 64'((i == 0) ? rdy0[s] : rdy1[s]), 64'(1));
        check_value("reset_occ", i, 64'((i == 0) ? occ0[s] : occ1[s]), 64'(0));
      end
    end
  endtask

  // Drives one instance for one cycle and advances the model of what the bus must do
  task automatic apply_stimulus(input int i, input logic fl);
    logic [NSRC-1:0]     v, acc, granted;
    CDB_ENTRY [NSRC-1:0] e;
    lanes_t              lanes;
    CDB_ENTRY            got [$];
    CDB_ENTRY            r;
    int                  start, last, s;
    bit                  was_empty;
    for (int k = 0; k < NSRC; k++) begin
      v[k] = pend_v[i][k];
      e[k] = pend_v[i][k] ? pend_e[i][k]
                          : '{valid: 1'($urandom), tag: CDB_TAG_W'($urandom), data: $urandom};
      check_value("fu_ready", i, 64'((i == 0) ? rdy0[k] : rdy1[k]), 64'(mq[i][k].size() < DEP));
      check_value("occupancy", i, 64'((i == 0) ? occ0[k] : occ1[k]), 64'(mq[i][k].size()));
      acc[k] = v[k] && (mq[i][k].size() < DEP);
    end
    if (i == 0) begin
      fv0 = v; fe0 = e; fl0 = fl;
    end else begin
      fv1 = v; fe1 = e; fl1 = fl;
    end
    start   = (i == 1) ? mrr[i] : 0;
    last    = -1;
    granted = '0;
    for (int j = 0; j < NSRC; j++) begin
      s = (start + j) % NSRC;
      if ((mq[i][s].size() > 0 || acc[s]) && got.size() < NCDB) begin
        r       = (mq[i][s].size() > 0) ? mq[i][s][0] : e[s];
        r.valid = 1'b1;
        got.push_back(r);
        granted[s] = 1'b1;
        last       = s;
      end
    end
    for (int k = 0; k < NCDB; k++) begin
      lanes[k] = (k < got.size()) ? got[k] : '0;
    end
    if (fl) begin
      lanes = '0;
      for (int k = 0; k < NSRC; k++) mq[i][k].delete();
    end else begin
      for (int k = 0; k < NSRC; k++) begin
        was_empty = (mq[i][k].size() == 0);
        if (granted[k] && !was_empty) void'(mq[i][k].pop_front());
        if (acc[k] && !(granted[k] && was_empty)) mq[i][k].push_back(e[k]);
      end
      if (last >= 0) mrr[i] = (last + 1) % NSRC;
    end
    exp_q[i].push_back(lanes);
    for (int k = 0; k < NSRC; k++) begin
      if (acc[k]) pend_v[i][k] = 1'b0;
    end
  endtask

  task automatic offer(input int i, input int s, input int tag, input logic [31:0] data);
    pend_v[i][s] = 1'b1;
    pend_e[i][s] = '{valid: 1'($urandom), tag: CDB_TAG_W'(tag), data: data};
  endtask

  // A producer with nothing outstanding creates a fresh result; otherwise it keeps holding
  task automatic offer_new(input int i, input int s);
    if (!pend_v[i][s]) begin
      offer(i, s, next_tag[i], $urandom);
      next_tag[i] = (next_tag[i] + 1) % 64;
    end
  endtask

  task automatic offer_all();
    for (int i = 0; i < 2; i++)
      for (int s = 0; s < NSRC; s++) offer_new(i, s);
  endtask

  task automatic cycle(input logic fl);
    @(negedge clock);
    apply_stimulus(0, fl);
    apply_stimulus(1, fl);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0);
  endtask

  task automatic mid_reset();
    @(posedge clock);
    #3;
    reset = 1'b0;
    fv0 = '0; fv1 = '0; fl0 = 1'b0; fl1 = 1'b0;
    #1;
    check_reset_state();
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < NSRC; s++) begin
        mq[i][s].delete();
        pend_v[i][s] = 1'b0;
      end
      exp_q[i].delete();
      mrr[i] = 0;
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    fv0 = '0; fv1 = '0; fe0 = '0; fe1 = '0; fl0 = 1'b0; fl1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mrr[i]      = 0;
      next_tag[i] = 1;
      for (int s = 0; s < NSRC; s++) pend_v[i][s] = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    $display("[TB] checking reset state");
    check_reset_state();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    $display("[TB] bypass from a single source");
    offer(0, 2, 7, 32'h55);
    offer(1, 2, 7, 32'h55);
    cycle(1'b0);
    idle(2);

    $display("[TB] all sources contend for one cycle");
    for (int i = 0; i < 2; i++)
      for (int s = 0; s < NSRC; s++) offer(i, s, s + 1, $urandom);
    cycle(1'b0);
    idle(3);

    $display("[TB] backpressure on a low-priority source");
    repeat (6) begin
      for (int i = 0; i < 2; i++) begin
        offer_new(i, 0);
        offer_new(i, 1);
        offer_new(i, 3);
      end
      cycle(1'b0);
    end
    idle(6);

    $display("[TB] continuous load on all sources");
    repeat (8) begin
      offer_all();
      cycle(1'b0);
    end
    idle(4);

    $display("[TB] flush with buffered entries");
    offer_all();
    cycle(1'b0);
    offer_all();
    cycle(1'b0);
    for (int i = 0; i < 2; i++) offer_new(i, 1);
    cycle(1'b1);
    offer_all();
    cycle(1'b0);
    idle(4);

    $display("[TB] asynchronous reset mid-operation");
    repeat (3) begin
      offer_all();
      cycle(1'b0);
    end
    mid_reset();
    offer_all();
    cycle(1'b0);
    idle(3);

    $display("[TB] randomized traffic");
    repeat (300) begin
      for (int i = 0; i < 2; i++)
        for (int s = 0; s < NSRC; s++)
          if ($urandom_range(0, 99) < 60) offer_new(i, s);
      cycle($urandom_range(0, 29) == 0);
    end
    idle(8);

    @(posedge clock);
    #2;
    for (int i = 0; i < 2; i++) begin
      check_value("drain", i, 64'(exp_q[i].size()), 64'(0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
